// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO: drain-FSM states,
// the busy-handshake timeout and the default FIFO depth.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } drain_state_t;

    localparam int BUSY_TIMEOUT  = 4;
    localparam int DEFAULT_DEPTH = 16;

    // Sized so that a timeout of 1 still gets a non-zero-width counter.
    localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side push port, status flags and UART transmitter handshake of the
// transmit FIFO, bundled as one interface.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) ();

    logic [7:0]             wr_data;
    logic                   wr_en;
    logic                   tx_busy;
    logic [7:0]             tx_data;
    logic                   tx_wr;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport master (
        output wr_data,
        output wr_en,
        output tx_busy,
        input  tx_data,
        input  tx_wr,
        input  full,
        input  empty,
        input  count,
        input  overflow
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        input  tx_busy,
        output tx_data,
        output tx_wr,
        output full,
        output empty,
        output count,
        output overflow
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// Byte storage for the transmit FIFO: synchronous write, combinational read.
// Contents are deliberately not reset; pointers alone define validity.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [7:0]               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [7:0]               o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART transmitter: buffers host bytes and drains
// them one at a time using the transmitter's busy flag as the handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for data in the FIFO and an idle transmitter
// ISSUE      | tx_wr high for one cycle, head byte on tx_data, pop
// WAIT_BUSY  | waiting for the transmitter to raise busy; bounded timeout
// WAIT_DONE  | transmitter busy; waiting for it to finish
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;

    drain_state_t       r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_tx_wr;
    logic [7:0]         r_tx_data;

    logic               w_push;
    logic               w_pop;
    logic [PW-1:0]      w_wr_ptr_nxt;
    logic [PW-1:0]      w_rd_ptr_nxt;
    logic [7:0]         w_head;

    // A push against a full FIFO is dropped even if this cycle also pops.
    assign w_push = bus.wr_en && !r_full;
    assign w_pop  = (r_state == ST_ISSUE) && !r_empty;

    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    uart_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    // Flags are computed from next-state pointers so they stay registered
    // yet agree with the pointers after every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_empty && !bus.tx_busy) begin
                        r_state   <= ST_ISSUE;
                        r_tx_wr   <= 1'b1;
                        r_tx_data <= w_head;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_BUSY;
                    r_timer <= TIMER_W'(BUSY_TIMEOUT - 1);
                end
                ST_WAIT_BUSY: begin
                    // No busy response in time: treat the byte as sent.
                    if (bus.tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_wr    = r_tx_wr;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple UART transmitter
// busy model (10 bit-times of 2 clocks each).
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       busy_force = 1'b0;
    bit         use_model  = 1'b0;
    int         model_cnt  = 0;
    int         cyc        = 0;
    int         last_pulse = -100;
    int         pulse_cnt  = 0;
    int         n_chk      = 0;
    int         n_pass     = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_busy = use_model ? (model_cnt != 0) : busy_force;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (use_model && bus.tx_wr)
            model_cnt <= 20;
        else if (model_cnt > 0)
            model_cnt <= model_cnt - 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.tx_wr === 1'b1) begin
            pulse_cnt++;
            got_q.push_back(bus.tx_data);
            check_eq("tx_wr_while_busy", 32'(bus.tx_busy), 32'd0);
            check_eq("tx_wr_spacing", 32'((cyc - last_pulse) >= 3), 32'd1);
            last_pulse = cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit keep);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        if (keep) exp_q.push_back(d);
    endtask

    task automatic wait_tx_wr(input int max, output int waited);
        waited = 0;
        while (bus.tx_wr !== 1'b1 && waited < max) begin
            tick();
            waited++;
        end
        check_eq("tx_wr_seen", 32'(bus.tx_wr), 32'd1);
    endtask

    task automatic wait_rx(input int n, input int max);
        int w;
        w = 0;
        while (got_q.size() < n && w < max) begin
            tick();
            w++;
        end
        check_eq("rx_arrived", 32'(got_q.size()), 32'(n));
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset values
        reset = 1'b1;
        repeat (2) tick();
        check_eq("rst_count",    32'(bus.count),    32'd0);
        check_eq("rst_empty",    32'(bus.empty),    32'd1);
        check_eq("rst_full",     32'(bus.full),     32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_tx_wr",    32'(bus.tx_wr),    32'd0);
        check_eq("rst_tx_data",  32'(bus.tx_data),  32'h00);
        reset = 1'b0;
        tick();

        // Single byte, idle transmitter: tx_wr two edges after the push
        push_byte(8'h41, 1'b1);
        check_eq("t1_tx_wr_early", 32'(bus.tx_wr), 32'd0);
        check_eq("t1_count",       32'(bus.count), 32'd1);
        check_eq("t1_empty_push",  32'(bus.empty), 32'd0);
        tick();
        check_eq("t1_tx_wr",       32'(bus.tx_wr),   32'd1);
        check_eq("t1_tx_data",     32'(bus.tx_data), 32'h41);
        tick();
        check_eq("t1_tx_wr_pulse", 32'(bus.tx_wr), 32'd0);
        check_eq("t1_empty_pop",   32'(bus.empty), 32'd1);
        check_eq("t1_count_pop",   32'(bus.count), 32'd0);
        check_eq("t1_tx_data_hold", 32'(bus.tx_data), 32'h41);
        repeat (8) tick();
        compare_stream("t1");

        // Fill with transmitter stuck busy, then overflow
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check_eq("t2_full",     32'(bus.full),     32'd1);
        check_eq("t2_count",    32'(bus.count),    32'd16);
        check_eq("t2_empty",    32'(bus.empty),    32'd0);
        check_eq("t2_overflow_pre", 32'(bus.overflow), 32'd0);
        push_byte(8'hEE, 1'b0);
        check_eq("t2_overflow", 32'(bus.overflow), 32'd1);
        check_eq("t2_count_ovf", 32'(bus.count),   32'd16);
        check_eq("t2_full_ovf", 32'(bus.full),     32'd1);
        check_eq("t2_no_tx_busy", 32'(got_q.size()), 32'd0);

        // Drain through the transmitter model
        use_model = 1'b1;
        wait_rx(16, 1000);
        repeat (30) tick();
        check_eq("t3_count",    32'(bus.count),    32'd0);
        check_eq("t3_empty",    32'(bus.empty),    32'd1);
        check_eq("t3_full",     32'(bus.full),     32'd0);
        check_eq("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
        compare_stream("t3");

        // Push on every pop at count=5, across pointer wrap
        use_model  = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b1);
        check_eq("t4_count_init", 32'(bus.count), 32'd5);
        busy_force = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_tx_wr(20, n);
            push_byte(8'(8'h60 + i), 1'b1);
            check_eq($sformatf("t4_count_steady%0d", i), 32'(bus.count), 32'd5);
        end
        wait_rx(25, 300);
        repeat (10) tick();
        check_eq("t4_count_end", 32'(bus.count), 32'd0);
        check_eq("t4_empty_end", 32'(bus.empty), 32'd1);
        compare_stream("t4");

        // Transmitter never raises busy: timeout back to IDLE, next byte issues
        push_byte(8'hA0, 1'b1);
        push_byte(8'hA1, 1'b1);
        check_eq("t5_first_issue", 32'(bus.tx_wr), 32'd1);
        tick();
        wait_tx_wr(20, n);
        check_eq("t5_timeout_gap", 32'(n + 1), 32'd6);
        check_eq("t5_tx_data", 32'(bus.tx_data), 32'hA1);
        repeat (10) tick();
        check_eq("t5_empty", 32'(bus.empty), 32'd1);
        compare_stream("t5");

        // Reset during WAIT_DONE with 3 bytes still queued
        busy_force = 1'b1;
        push_byte(8'hB0, 1'b1);
        push_byte(8'hB1, 1'b0);
        push_byte(8'hB2, 1'b0);
        push_byte(8'hB3, 1'b0);
        use_model = 1'b1;
        wait_tx_wr(60, n);
        repeat (3) tick();
        check_eq("t6_queued",          32'(bus.count),    32'd3);
        check_eq("t6_overflow_sticky", 32'(bus.overflow), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_count",    32'(bus.count),    32'd0);
        check_eq("t6_rst_empty",    32'(bus.empty),    32'd1);
        check_eq("t6_rst_full",     32'(bus.full),     32'd0);
        check_eq("t6_rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("t6_rst_tx_wr",    32'(bus.tx_wr),    32'd0);
        check_eq("t6_rst_tx_data",  32'(bus.tx_data),  32'h00);
        p = pulse_cnt;
        reset      = 1'b0;
        use_model  = 1'b0;
        busy_force = 1'b0;
        repeat (30) tick();
        check_eq("t6_no_tx_after_reset", 32'(pulse_cnt), 32'(p));
        check_eq("t6_empty_after", 32'(bus.empty), 32'd1);
        compare_stream("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; legal values are powers of two, 2..256.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 wr_data  input  8  byte from the host side.
REQ-005 wr_en  input  1  one-cycle strobe; push wr_data.
REQ-006 tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-007 tx_data  output  8  byte presented to the UART transmitter.
REQ-008 tx_wr  output  1  one-cycle strobe to the UART transmitter's write input.
REQ-009 full  output  1  FIFO holds DEPTH bytes.
REQ-010 empty  output  1  FIFO holds 0 bytes.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky; a push was dropped.

Function
REQ-013 Storage: circular buffer; read/write pointers are $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty are derived from pointer MSB and the remaining bits.
REQ-014 Push: wr_en=1 and full=0 -> byte stored, write pointer +1, count +1 on the same edge.
REQ-015 Push when full: byte dropped, pointers unchanged, overflow set to 1; this holds even if a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop (not full): both take effect; count unchanged.
REQ-017 Drain FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: empty=0 and tx_busy=0 -> ISSUE; otherwise stay.
REQ-019 ISSUE (one cycle): tx_wr=1, tx_data=head byte, read pointer +1 (pop); -> WAIT_BUSY.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; after 4 cycles without tx_busy=1 -> IDLE (timeout, byte considered sent).
REQ-021 WAIT_DONE: tx_busy=0 -> IDLE; no timeout.
REQ-022 tx_data is registered; it is loaded on entry to ISSUE and held stable until the next ISSUE.
REQ-023 tx_wr is registered; it is high only in ISSUE; two tx_wr pulses are separated by at least 3 cycles.
REQ-024 Latency: push into an empty FIFO while idle with tx_busy=0 -> tx_wr high 2 edges later.
REQ-025 full, empty and count are registered and consistent with pointers after every edge.
REQ-026 overflow clears only on reset.

Reset
REQ-027 On reset: pointers=0, count=0, empty=1, full=0, overflow=0, tx_wr=0, tx_data=8'h00, FSM=IDLE.
REQ-028 Reset mid-transfer: FIFO contents are discarded; no further tx_wr until new data is pushed after reset deasserts.
REQ-029 FIFO storage array is not reset.

Structure
REQ-030 Shared package uart_pkg: drain-FSM state enum (logic[1:0]), BUSY_TIMEOUT=4 constant, default DEPTH constant.
REQ-031 One sub-module, uart_fifo_ram: DEPTH x 8 synchronous-write, combinational-read array; pointer, flag and FSM logic stay in uart_tx_fifo.

Verification
REQ-032 Reset, then push 8'h41 with tx_busy held 0 -> tx_wr high 2 edges later with tx_data=8'h41; empty=1 after the pop.
REQ-033 Push 16 bytes 8'h00..8'h0F with tx_busy stuck at 1 -> full=1, count=16; 17th push -> overflow=1, count stays 16.
REQ-034 Then release tx_busy using a UART transmitter model (busy for 10 bit-times) -> bytes leave in order 8'h00..8'h0F, one tx_wr per busy period, never while tx_busy=1.
REQ-035 Push while popping at count=5 -> count remains 5 and data order is preserved across pointer wrap (>2*DEPTH bytes total).
REQ-036 tx_busy never asserts after tx_wr -> FSM returns to IDLE after 4 cycles and the next byte issues.
REQ-037 Assert reset during WAIT_DONE with 3 bytes queued -> count=0, empty=1, overflow=0, no tx_wr after reset deasserts.
